// File: rtl/ofifo_rowbuf.sv
// ofifo_rowbuf: output FIFO for the systolic-array psum path.
//   One circular buffer per column. Each column is pushed on its own strobe, so
//   skewed psum arrivals are absorbed. Data is read back either as an aligned row
//   or one column at a time (serial mode) for narrow write-back.
//   Output is first-word-fall-through from registered pointers and counts.
//
// Ports:
//   clk      clock, all state on posedge
//   reset    synchronous, active-high
//   in       column i data at in[bw*(i+1)-1:bw*i]
//   wr       per-column push strobe
//   rd       pop request (whole row, or column o_sel in serial mode)
//   mode     0 = row read, 1 = column-serial read
//   out      row mode: head row; serial mode: head of column o_sel in out[bw-1:0]
//   o_valid  out holds poppable data this cycle
//   o_full   some column is full
//   o_ready  every column can take a push
//   o_sel    column addressed in serial mode
//   o_count  per-column occupancy, column i at [(aw+1)*(i+1)-1:(aw+1)*i]
//   o_err    {rd_underflow, wr_overflow}, sticky
//
// Build option: define OFIFO_ERR_EN to enable the sticky error flags; otherwise
// o_err is tied to 2'b00.
module ofifo_rowbuf #(
    parameter  int col   = 8,
    parameter  int bw    = 16,
    parameter  int depth = 16,
    localparam int aw    = $clog2(depth),
    localparam int sw    = (col > 1) ? $clog2(col) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [bw*col-1:0]     in,
    input  logic [col-1:0]        wr,
    input  logic                  rd,
    input  logic                  mode,
    output logic [bw*col-1:0]     out,
    output logic                  o_valid,
    output logic                  o_full,
    output logic                  o_ready,
    output logic [sw-1:0]         o_sel,
    output logic [(aw+1)*col-1:0] o_count,
    output logic [1:0]            o_err
);

    logic [bw-1:0] mem    [col][depth];
    logic [aw-1:0] wr_ptr [col];
    logic [aw-1:0] rd_ptr [col];
    logic [aw:0]   count  [col];

    logic [col-1:0] full;
    logic [col-1:0] empty;
    logic [col-1:0] pop;
    logic [col-1:0] push;

    // Flags come only from registered counts; wr/rd never reach them combinationally.
    always_comb begin
        for (int i = 0; i < col; i++) begin
            full[i]                     = (count[i] == (aw+1)'(depth));
            empty[i]                    = (count[i] == '0);
            o_count[(aw+1)*i +: (aw+1)] = count[i];
        end
        o_full  = |full;
        o_ready = ~o_full;
        o_valid = mode ? ~empty[o_sel] : &(~empty);
    end

    // A pop frees a slot in the same cycle, so a full column may still accept a push.
    always_comb begin
        for (int i = 0; i < col; i++) begin
            pop[i]  = rd & o_valid & (~mode | (o_sel == sw'(i)));
            push[i] = wr[i] & (~full[i] | pop[i]);
        end
    end

    // Zero whenever nothing is poppable so downstream never sees stale words.
    always_comb begin
        out = '0;
        if (o_valid) begin
            if (mode) begin
                out[bw-1:0] = mem[o_sel][rd_ptr[o_sel]];
            end else begin
                for (int i = 0; i < col; i++) begin
                    out[bw*i +: bw] = mem[i][rd_ptr[i]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in[bw*i +: bw];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < col; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            o_sel <= '0;
        end else begin
            for (int i = 0; i < col; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
            // Serial walks always restart at column 0 after any row-mode cycle.
            if (!mode) begin
                o_sel <= '0;
            end else if (rd && o_valid) begin
                o_sel <= (o_sel == sw'(col - 1)) ? '0 : o_sel + 1'b1;
            end
        end
    end

`ifdef OFIFO_ERR_EN
    logic [1:0] err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 2'b00;
        end else begin
            if (|(wr & full & ~pop)) begin
                err_q[0] <= 1'b1;
            end
            if (rd && !o_valid) begin
                err_q[1] <= 1'b1;
            end
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 2'b00;
`endif

endmodule
